// File: rtl/vga_frame_buffer.sv
// Ping-pong heat-map frame store feeding the VGA display stage.
// Producer fills the back bank; banks swap only on a VGA frame boundary, then the new back bank is zero-filled.
module vga_frame_buffer #(
  parameter int COLS   = 60,
  parameter int ROWS   = 45,
  parameter int STRIDE = 80,
  parameter int DEPTH  = ROWS * STRIDE,
  parameter int DW     = 16
) (
  input  logic          i_clk_25M,
  input  logic          i_rst,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [5:0]    i_wr_x,
  input  logic [5:0]    i_wr_y,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_frame_done,
  input  logic          i_vga_finish,
  input  logic [12:0]   i_rd_address,
  output logic [DW-1:0] o_rd_data,
  output logic          o_front_valid,
  output logic          o_wr_err,
  output logic [7:0]    o_frame_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [12:0] DEPTH_A  = 13'(DEPTH);
  localparam logic [12:0] STRIDE_A = 13'(STRIDE);
  localparam logic [11:0] LAST_A   = 12'(DEPTH - 1);
  localparam logic [5:0]  COLS_C   = 6'(COLS);
  localparam logic [5:0]  ROWS_C   = 6'(ROWS);

  typedef enum logic [1:0] {S_CLEAR, S_FILL, S_SWAP_WAIT} state_t;

  state_t          r_state, w_next;
  logic            r_bank_sel;
  logic            r_front_valid;
  logic            r_wr_err;
  logic [7:0]      r_frame_count;
  logic [11:0]     r_clr_addr;
  logic            r_rd_mask;
  logic            r_rd_sel;
  logic [DW-1:0]   r_rd0, r_rd1;
  logic [DW-1:0]   r_mem0 [DEPTH];
  logic [DW-1:0]   r_mem1 [DEPTH];

  logic [12:0]     w_wr_addr;
  logic            w_in_range, w_accept, w_swap, w_we, w_we0, w_we1;
  logic [AW-1:0]   w_waddr, w_rd_idx;
  logic [DW-1:0]   w_wdata;

  assign o_wr_ready = (r_state == S_FILL);
  assign w_wr_addr  = 13'(i_wr_y) * STRIDE_A + 13'(i_wr_x);
  // The address bound also guards parameterisations where STRIDE < COLS.
  assign w_in_range = (i_wr_x < COLS_C) && (i_wr_y < ROWS_C) && (w_wr_addr < DEPTH_A);
  assign w_accept   = i_wr_valid && o_wr_ready;
  assign w_swap     = (r_state == S_SWAP_WAIT) && (!r_front_valid || i_vga_finish);

  assign w_we    = (r_state == S_CLEAR) || (w_accept && w_in_range);
  assign w_waddr = (r_state == S_CLEAR) ? AW'(r_clr_addr) : AW'(w_wr_addr);
  assign w_wdata = (r_state == S_CLEAR) ? '0 : i_wr_data;
  // Front bank is r_bank_sel, so writes always land in the other one.
  assign w_we0   = w_we && r_bank_sel;
  assign w_we1   = w_we && !r_bank_sel;

  assign w_rd_idx = (i_rd_address < DEPTH_A) ? AW'(i_rd_address) : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR:     if (r_clr_addr == LAST_A) w_next = S_FILL;
      S_FILL:      if (i_frame_done) w_next = S_SWAP_WAIT;
      S_SWAP_WAIT: if (w_swap) w_next = S_CLEAR;
      default:     w_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk_25M or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_CLEAR;
      r_clr_addr    <= '0;
      r_bank_sel    <= 1'b0;
      r_front_valid <= 1'b0;
      r_wr_err      <= 1'b0;
      r_frame_count <= '0;
      r_rd_mask     <= 1'b0;
      r_rd_sel      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_clr_addr <= (r_state == S_CLEAR && r_clr_addr != LAST_A) ? r_clr_addr + 12'd1 : '0;
      r_wr_err   <= w_accept && !w_in_range;
      r_rd_mask  <= r_front_valid && (i_rd_address < DEPTH_A);
      r_rd_sel   <= r_bank_sel;
      if (w_swap) begin
        r_bank_sel    <= ~r_bank_sel;
        r_front_valid <= 1'b1;
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  // Storage: each bank has one write port and one registered read port.
  always_ff @(posedge i_clk_25M) begin
    if (w_we0) r_mem0[w_waddr] <= w_wdata;
    if (!r_bank_sel) r_rd0 <= r_mem0[w_rd_idx];
  end

  always_ff @(posedge i_clk_25M) begin
    if (w_we1) r_mem1[w_waddr] <= w_wdata;
    if (r_bank_sel) r_rd1 <= r_mem1[w_rd_idx];
  end

  assign o_rd_data     = !r_rd_mask ? '0 : (r_rd_sel ? r_rd1 : r_rd0);
  assign o_front_valid = r_front_valid;
  assign o_wr_err      = r_wr_err;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Directed bench for vga_frame_buffer: full-size instance for data/swap behaviour,
// a one-row instance running in parallel for the 8-bit frame counter wrap.
module tb_vga_frame_buffer;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst, wr_valid, wr_ready, frame_done, vga_finish, front_valid, wr_err;
  logic [5:0]  wr_x, wr_y;
  logic [15:0] wr_data, rd_data;
  logic [12:0] rd_address;
  logic [7:0]  frame_count;

  logic        b_rst, b_wr_ready, b_frame_done, b_vga_finish, b_front_valid, b_wr_err;
  logic [15:0] b_rd_data;
  logic [7:0]  b_frame_count;
  logic        b_done = 1'b0;

  vga_frame_buffer dut (
    .i_clk_25M(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_x(wr_x), .i_wr_y(wr_y), .i_wr_data(wr_data), .i_frame_done(frame_done),
    .i_vga_finish(vga_finish), .i_rd_address(rd_address), .o_rd_data(rd_data),
    .o_front_valid(front_valid), .o_wr_err(wr_err), .o_frame_count(frame_count)
  );

  vga_frame_buffer #(.ROWS(1), .STRIDE(80)) dut_b (
    .i_clk_25M(clk), .i_rst(b_rst), .i_wr_valid(1'b0), .o_wr_ready(b_wr_ready),
    .i_wr_x(6'd0), .i_wr_y(6'd0), .i_wr_data(16'd0), .i_frame_done(b_frame_done),
    .i_vga_finish(b_vga_finish), .i_rd_address(13'd0), .o_rd_data(b_rd_data),
    .o_front_valid(b_front_valid), .o_wr_err(b_wr_err), .o_frame_count(b_frame_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts rising edges until the selected instance shows o_wr_ready at a falling edge.
  task automatic wait_rdy(input bit inst_b, input int bound, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(inst_b ? b_wr_ready : wr_ready) && n < bound);
    if (!(inst_b ? b_wr_ready : wr_ready)) check("ready_timeout", 32'(n), 32'(bound + 1));
  endtask

  typedef struct {
    bit          do_wr;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [15:0] data;
    bit          exp_err;
    logic [12:0] addr;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{1'b1, 6'd5,  6'd2,  16'hABCD, 1'b0, 13'd165,  16'hABCD};
    vecs[1] = '{1'b1, 6'd59, 6'd44, 16'hBEEF, 1'b0, 13'd3579, 16'hBEEF};
    vecs[2] = '{1'b1, 6'd60, 6'd0,  16'h1111, 1'b1, 13'd60,   16'h0000};
    vecs[3] = '{1'b1, 6'd0,  6'd45, 16'h2222, 1'b1, 13'd3600, 16'h0000};
    vecs[4] = '{1'b1, 6'd0,  6'd0,  16'h0001, 1'b0, 13'd0,    16'h0001};
    vecs[5] = '{1'b1, 6'd59, 6'd0,  16'h5A5A, 1'b0, 13'd59,   16'h5A5A};
    vecs[6] = '{1'b0, 6'd0,  6'd0,  16'h0000, 1'b0, 13'd3599, 16'h0000};
    vecs[7] = '{1'b0, 6'd0,  6'd0,  16'h0000, 1'b0, 13'd8191, 16'h0000};

    rst = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    frame_done = 1'b0; vga_finish = 1'b0; rd_address = 13'd165;
    repeat (3) cyc();
    check("rst_ready", 32'(wr_ready), 32'd0);
    check("rst_front_valid", 32'(front_valid), 32'd0);
    check("rst_count", 32'(frame_count), 32'd0);
    check("rst_err", 32'(wr_err), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);

    rst = 1'b0;
    wait_rdy(1'b0, 5000, n);
    check("clear_len", 32'(n), 32'd3600);
    check("rd_masked_165", 32'(rd_data), 32'd0);
    rd_address = 13'd0;
    cyc();
    check("rd_masked_0", 32'(rd_data), 32'd0);

    // Frame 1: table of writes, then swap (no front yet), then table of reads
    foreach (vecs[i]) begin
      if (vecs[i].do_wr) begin
        wr_valid = 1'b1; wr_x = vecs[i].x; wr_y = vecs[i].y; wr_data = vecs[i].data;
        cyc();
        wr_valid = 1'b0;
        check($sformatf("wr_err_v%0d", i), 32'(wr_err), 32'(vecs[i].exp_err));
        cyc();
        check($sformatf("wr_err_clr_v%0d", i), 32'(wr_err), 32'd0);
      end
    end
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    check("f1_wait_ready", 32'(wr_ready), 32'd0);
    cyc();
    check("f1_front_valid", 32'(front_valid), 32'd1);
    check("f1_count", 32'(frame_count), 32'd1);
    foreach (vecs[i]) begin
      rd_address = vecs[i].addr;
      cyc();
      check($sformatf("rd_v%0d_addr%0d", i, vecs[i].addr), 32'(rd_data), 32'(vecs[i].exp_rd));
    end

    // Finish outside the swap wait has no effect
    vga_finish = 1'b1;
    cyc();
    vga_finish = 1'b0;
    wait_rdy(1'b0, 5000, n);
    check("finish_ignored_count", 32'(frame_count), 32'd1);

    // Frame 2: write committed alongside frame_done; coincident finish ignored
    rd_address = 13'd165;
    wr_valid = 1'b1; wr_x = 6'd5; wr_y = 6'd2; wr_data = 16'h1234;
    frame_done = 1'b1; vga_finish = 1'b1;
    cyc();
    wr_valid = 1'b0; frame_done = 1'b0; vga_finish = 1'b0;
    check("f2_wait_ready", 32'(wr_ready), 32'd0);
    check("f2_count_hold", 32'(frame_count), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("f2_old_data", 32'(rd_data), 32'hABCD);
    end
    vga_finish = 1'b1;
    cyc();
    vga_finish = 1'b0;
    check("f2_count", 32'(frame_count), 32'd2);
    check("f2_swap_cycle_rd", 32'(rd_data), 32'hABCD);
    cyc();
    check("f2_new_data", 32'(rd_data), 32'h1234);

    // Frame 3: empty frame exposes the zero-filled bank
    wait_rdy(1'b0, 5000, n);
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    vga_finish = 1'b1;
    cyc();
    vga_finish = 1'b0;
    check("f3_count", 32'(frame_count), 32'd3);
    rd_address = 13'd165;
    cyc();
    check("f3_cleared_165", 32'(rd_data), 32'd0);
    rd_address = 13'd3579;
    cyc();
    check("f3_cleared_3579", 32'(rd_data), 32'd0);

    // frame_done during clear is dropped, not queued
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    wait_rdy(1'b0, 5000, n);
    cyc();
    check("done_not_queued", 32'(wr_ready), 32'd1);

    // Reset during swap wait
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    check("sw_wait_ready", 32'(wr_ready), 32'd0);
    #5 rst = 1'b1;
    #1;
    check("mid_rst_front_valid", 32'(front_valid), 32'd0);
    check("mid_rst_count", 32'(frame_count), 32'd0);
    check("mid_rst_rd", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_rdy(1'b0, 5000, n);
    check("reclear_len", 32'(n), 32'd3600);
    rd_address = 13'd165;
    cyc();
    check("reclear_rd_masked", 32'(rd_data), 32'd0);

    n = 0;
    while (!b_done && n < 60000) begin
      cyc();
      n++;
    end
    check("wrap_done", 32'(b_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Counter wrap on the small instance; finish held high so every wait swaps at once.
  initial begin
    int n;
    b_rst = 1'b1; b_frame_done = 1'b0; b_vga_finish = 1'b1;
    repeat (2) cyc();
    b_rst = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      wait_rdy(1'b1, 300, n);
      if (!b_wr_ready) break;
      b_frame_done = 1'b1;
      cyc();
      b_frame_done = 1'b0;
      cyc();
      check($sformatf("wrap_count_%0d", k), 32'(b_frame_count), 32'(k % 256));
    end
    check("wrap_front_valid", 32'(b_front_valid), 32'd1);
    b_done = 1'b1;
  end

endmodule

// File: doc/vga_frame_buffer.md
Name: vga_frame_buffer

Overview:
- Double-buffered (ping-pong) heat-map frame store directly upstream of the VGA display stage.
- A producer writes 60x45 16-bit cell values into the back bank while the VGA stage reads the front bank through its 13-bit access address.
- Banks swap only at a VGA frame boundary, so a displayed frame never mixes two data sets.
- The newly exposed back bank is zero-filled after each swap.

Parameters:
- COLS, 60, cells per row written by the producer.
- ROWS, 45, rows of cells.
- STRIDE, 80, address stride per row (read address = y*STRIDE + x).
- DEPTH, 3600, words per bank (ROWS*STRIDE).
- DW, 16, data width.

Ports:
- i_clk_25M  in  1  pixel clock, shared with VGA stage
- i_rst  in  1  asynchronous reset, active-high
- i_wr_valid  in  1  producer write request
- o_wr_ready  out  1  write accepted when valid&ready
- i_wr_x  in  6  cell column
- i_wr_y  in  6  cell row
- i_wr_data  in  16  cell value
- i_frame_done  in  1  pulse: back bank complete, request swap
- i_vga_finish  in  1  end-of-frame pulse from VGA stage
- i_rd_address  in  13  VGA access address
- o_rd_data  out  16  cell value to VGA i_display_data
- o_front_valid  out  1  front bank holds a completed frame
- o_wr_err  out  1  one-cycle pulse: accepted write had out-of-range coordinate
- o_frame_count  out  8  completed swaps, wraps 255->0

Behaviour:
- Reset values:
  - bank select = 0 (front = bank 0).
  - o_front_valid = 0, o_wr_err = 0, o_frame_count = 0, o_rd_data = 0, o_wr_ready = 0.
  - FSM enters S_CLEAR.
- Storage: two DEPTH x DW synchronous RAMs.
- Read path:
  - Registered, latency 1: o_rd_data in cycle n+1 reflects i_rd_address in cycle n.
  - The VGA stage tolerates this as a one-pixel horizontal shift.
  - o_rd_data = 0 when i_rd_address >= DEPTH or o_front_valid = 0 (both evaluated at sample time).
- FSM states:
  - S_CLEAR:
    - Writes 0 to back-bank address 0..DEPTH-1, one per cycle, via a 12-bit counter.
    - o_wr_ready = 0.
    - After address DEPTH-1, go to S_FILL. Duration is exactly DEPTH cycles.
  - S_FILL:
    - o_wr_ready = 1.
    - On valid&ready with x<COLS and y<ROWS: back[y*STRIDE+x] <= data.
    - Otherwise the write is dropped but still accepted, and o_wr_err pulses in the next cycle.
    - i_frame_done goes to S_SWAP_WAIT. A write in the same cycle as frame_done is committed first.
  - S_SWAP_WAIT:
    - o_wr_ready = 0.
    - If o_front_valid = 0, swap on the next cycle unconditionally.
    - Otherwise swap in the first cycle with i_vga_finish = 1. A finish pulse coincident with the i_frame_done cycle does not count.
    - Swap actions: toggle bank select, set o_front_valid = 1, increment o_frame_count, go to S_CLEAR.
- i_frame_done outside S_FILL is ignored; no queuing.
- i_vga_finish outside S_SWAP_WAIT has no effect.
- Read and write never touch the same bank in the same cycle. The swap takes effect on the read port from the cycle after the swap cycle.
- Reset mid-operation: all state returns to reset values immediately (async). RAM contents are not guaranteed; the front bank is masked by o_front_valid = 0.
- Address arithmetic: y*STRIDE+x is computed at 13 bits; no overflow for in-range coordinates (max 3579).

Test Plan:
- Reset, then idle: o_wr_ready stays 0 for exactly 3600 cycles, then goes to 1. o_rd_data = 0 for any address while o_front_valid = 0.
- First frame:
  - Stimulus: write (x=5, y=2, 0xABCD), pulse i_frame_done, no i_vga_finish.
  - Response: swap within 2 cycles; o_front_valid = 1; o_frame_count = 1.
  - Then read address 165: o_rd_data = 0xABCD one cycle later.
- Second frame:
  - Stimulus: write (5, 2, 0x1234), pulse frame_done.
  - Response: address 165 keeps reading 0xABCD until an i_vga_finish pulse; from the cycle after the swap it reads 0x1234; o_frame_count = 2.
- Out of range:
  - Stimulus: write (x=60, y=0) and (x=0, y=45).
  - Response: each is accepted, o_wr_err pulses once per write, and after a swap addresses 60 and 3600 read 0.
- Boundaries: i_rd_address = 3599 and 8191 both read 0; write (59, 44) reads back at address 3579. 256 swaps wrap o_frame_count to 0.
- Reset asserted during S_SWAP_WAIT: o_front_valid = 0 and o_frame_count = 0 immediately, and a fresh 3600-cycle clear follows release.
